// File: rtl/core0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core0_pkg
// Description : Shared core0 definitions: data word type and data-stack
//               movement encoding used by dstack_control and dstack_regs.
// Revision    : 1.0 - initial release
// ============================================================================
package core0_pkg;

  localparam int unsigned CORE_WORD_WIDTH = 32;

  typedef logic [CORE_WORD_WIDTH-1:0] word_t;
  typedef logic [1:0]                 mov_t;

  localparam mov_t MOV_KEEP = 2'b00;
  localparam mov_t MOV_PUSH = 2'b01;
  localparam mov_t MOV_POP1 = 2'b10;
  localparam mov_t MOV_POP2 = 2'b11;

endpackage : core0_pkg
`default_nettype wire

// File: rtl/dstack_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : dstack_regs_if
// Description : Bundle between dstack_control (master) and the data-stack
//               storage stage dstack_regs (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dstack_regs_if #(
  parameter int WORD_WIDTH  = 32,
  parameter int SPILL_DEPTH = 16
);
  localparam int CNT_WIDTH = $clog2(SPILL_DEPTH + 4);

  logic                  advance;
  logic [1:0]            movement;
  logic [WORD_WIDTH-1:0] next_top;
  logic                  clear;
  logic [WORD_WIDTH-1:0] top;
  logic [WORD_WIDTH-1:0] second;
  logic [WORD_WIDTH-1:0] third;
  logic [CNT_WIDTH-1:0]  depth;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output advance, movement, next_top, clear,
    input  top, second, third, depth, overflow, underflow
  );

  modport slave (
    input  advance, movement, next_top, clear,
    output top, second, third, depth, overflow, underflow
  );
endinterface : dstack_regs_if
`default_nettype wire

// File: rtl/dstack_spill_ram.sv
`default_nettype none
// ============================================================================
// Module      : dstack_spill_ram
// Description : Flop array holding data-stack entries below third.
//               One synchronous write port, two asynchronous read ports.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dstack_spill_ram #(
  parameter int WORD_WIDTH  = 32,
  parameter int SPILL_DEPTH = 16,
  parameter int ADDR_WIDTH  = $clog2(SPILL_DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  i_we,
  input  wire logic [ADDR_WIDTH-1:0] i_waddr,
  input  wire logic [WORD_WIDTH-1:0] i_wdata,
  input  wire logic [ADDR_WIDTH-1:0] i_raddr_a,
  output logic      [WORD_WIDTH-1:0] o_rdata_a,
  input  wire logic [ADDR_WIDTH-1:0] i_raddr_b,
  output logic      [WORD_WIDTH-1:0] o_rdata_b
);

  logic [WORD_WIDTH-1:0] r_mem [SPILL_DEPTH];

  // Single write port; storage has no reset so it maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule : dstack_spill_ram
`default_nettype wire

// File: rtl/dstack_regs.sv
`default_nettype none
// ============================================================================
// Module      : dstack_regs
// Description : Data-stack storage stage. Top three entries live in flops,
//               deeper entries spill to dstack_spill_ram. Tracks occupancy
//               and sticky overflow/underflow faults.
// Revision    : 1.0 - initial release
// ============================================================================
module dstack_regs
  import core0_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int SPILL_DEPTH = 16
) (
  input wire logic     clk,
  input wire logic     reset_n,
  dstack_regs_if.slave sif
);

  localparam int CNT_WIDTH = $clog2(SPILL_DEPTH + 4);
  localparam int PTR_WIDTH = CNT_WIDTH - 1;

  localparam logic [CNT_WIDTH-1:0] c_depth_max = CNT_WIDTH'(SPILL_DEPTH + 3);
  localparam logic [CNT_WIDTH-1:0] c_depth_0   = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] c_depth_1   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_depth_2   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] c_depth_3   = CNT_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0] c_depth_4   = CNT_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] c_depth_5   = CNT_WIDTH'(5);
  localparam logic [PTR_WIDTH-1:0] c_ptr_1     = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] c_ptr_2     = PTR_WIDTH'(2);

  logic [WORD_WIDTH-1:0] r_top, r_second, r_third;
  logic [PTR_WIDTH-1:0]  r_ptr;
  logic [CNT_WIDTH-1:0]  r_depth;
  logic                  r_overflow, r_underflow;

  mov_t                  w_mov;
  logic [PTR_WIDTH-1:0]  w_ptr_m1, w_ptr_m2;
  logic [WORD_WIDTH-1:0] w_rd_a, w_rd_b, w_fill_a, w_fill_b;
  logic                  w_fill_a_ok, w_fill_b_ok;
  logic                  w_full, w_spill_live, w_we;

  assign w_mov    = sif.movement;
  assign w_ptr_m1 = r_ptr - c_ptr_1;
  assign w_ptr_m2 = r_ptr - c_ptr_2;

  // Spill occupancy is derived from depth rather than ptr: at full depth the
  // pointer has wrapped to 0 while every spill slot is still live.
  assign w_fill_a_ok  = (r_depth >= c_depth_4);
  assign w_fill_b_ok  = (r_depth >= c_depth_5);
  assign w_fill_a     = w_fill_a_ok ? w_rd_a : '0;
  assign w_fill_b     = w_fill_b_ok ? w_rd_b : '0;
  assign w_full       = (r_depth == c_depth_max);
  assign w_spill_live = (r_depth >= c_depth_3);
  assign w_we         = sif.advance && !sif.clear && (w_mov == MOV_PUSH)
                        && w_spill_live && !w_full;

  dstack_spill_ram #(
    .WORD_WIDTH  (WORD_WIDTH),
    .SPILL_DEPTH (SPILL_DEPTH),
    .ADDR_WIDTH  (PTR_WIDTH)
  ) u_spill (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (r_ptr),
    .i_wdata   (r_third),
    .i_raddr_a (w_ptr_m1),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (w_ptr_m2),
    .o_rdata_b (w_rd_b)
  );

  // Stack flops, pointer, occupancy and sticky faults; clear beats advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_top       <= '0;
      r_second    <= '0;
      r_third     <= '0;
      r_ptr       <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (sif.clear) begin
      r_top       <= '0;
      r_second    <= '0;
      r_third     <= '0;
      r_ptr       <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (sif.advance) begin
      r_top <= sif.next_top;
      case (w_mov)
        MOV_KEEP: begin
          if (r_depth == c_depth_0) r_depth <= c_depth_1;
        end
        MOV_PUSH: begin
          r_second <= r_top;
          r_third  <= r_second;
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_depth <= r_depth + c_depth_1;
            if (w_spill_live) r_ptr <= r_ptr + c_ptr_1;
          end
        end
        MOV_POP1: begin
          r_second <= r_third;
          r_third  <= w_fill_a;
          if (w_fill_a_ok) r_ptr <= w_ptr_m1;
          if (r_depth < c_depth_2) begin
            r_depth     <= c_depth_1;
            r_underflow <= 1'b1;
          end else begin
            r_depth <= r_depth - c_depth_1;
          end
        end
        default: begin // MOV_POP2
          r_second <= w_fill_a;
          r_third  <= w_fill_b;
          if (w_fill_b_ok)      r_ptr <= w_ptr_m2;
          else if (w_fill_a_ok) r_ptr <= w_ptr_m1;
          if (r_depth < c_depth_3) begin
            r_depth     <= c_depth_1;
            r_underflow <= 1'b1;
          end else begin
            r_depth <= r_depth - c_depth_2;
          end
        end
      endcase
    end
  end

  assign sif.top       = r_top;
  assign sif.second    = r_second;
  assign sif.third     = r_third;
  assign sif.depth     = r_depth;
  assign sif.overflow  = r_overflow;
  assign sif.underflow = r_underflow;

endmodule : dstack_regs
`default_nettype wire

// File: tb/tb_dstack_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_dstack_regs
// Description : Directed self-checking bench for dstack_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dstack_regs;
  import core0_pkg::*;

  localparam int WORD_WIDTH  = 32;
  localparam int SPILL_DEPTH = 16;
  localparam int ST_W        = 3 * WORD_WIDTH + 5 + 2;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  logic [ST_W-1:0] e;

  dstack_regs_if #(.WORD_WIDTH(WORD_WIDTH), .SPILL_DEPTH(SPILL_DEPTH)) sif ();

  dstack_regs #(.WORD_WIDTH(WORD_WIDTH), .SPILL_DEPTH(SPILL_DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs observed outputs: {top, second, third, depth, overflow, underflow}.
  function automatic logic [ST_W-1:0] snap();
    return {sif.top, sif.second, sif.third, sif.depth, sif.overflow, sif.underflow};
  endfunction

  function automatic logic [ST_W-1:0] st(word_t t, word_t s, word_t th,
                                         logic [4:0] d, logic ov, logic un);
    return {t, s, th, d, ov, un};
  endfunction

  // Applies one set of inputs across one rising edge, returns 1 time unit later.
  task automatic drive(input logic adv, input mov_t mov, input word_t nt, input logic clr);
    sif.advance  = adv;
    sif.movement = mov;
    sif.next_top = nt;
    sif.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sif.advance = 1'b0; sif.movement = MOV_KEEP; sif.next_top = '0; sif.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    e = st(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL reset: got %h required %h", snap(), e); end
  endtask

  task automatic test_push_burst();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, MOV_PUSH, word_t'(i), 1'b0);
      if (i == 3) begin
        e = st(3, 2, 1, 3, 0, 0);
        n_tests++;
        if (snap() !== e) begin n_fail++; $display("FAIL push3: got %h required %h", snap(), e); end
      end
    end
    e = st(5, 4, 3, 5, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL push5: got %h required %h", snap(), e); end
  endtask

  task automatic test_pops();
    drive(1'b1, MOV_POP1, 32'h9, 1'b0);
    e = st(9, 3, 2, 4, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL pop1: got %h required %h", snap(), e); end
    drive(1'b1, MOV_POP2, 32'h7, 1'b0);
    e = st(7, 1, 0, 2, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL pop2: got %h required %h", snap(), e); end
  endtask

  task automatic test_overflow();
    // clear asserted together with an advancing push: clear must win
    drive(1'b1, MOV_PUSH, 32'hEE, 1'b1);
    e = st(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL clear_prio: got %h required %h", snap(), e); end
    for (int i = 1; i <= 19; i++) drive(1'b1, MOV_PUSH, word_t'(i), 1'b0);
    e = st(19, 18, 17, 19, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL fill19: got %h required %h", snap(), e); end
    drive(1'b1, MOV_PUSH, 32'hAA, 1'b0);
    e = st(32'hAA, 19, 18, 19, 1, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL ovf_push: got %h required %h", snap(), e); end
    // value 17 was dropped; the refill must come straight from spill slot 15 (=16)
    drive(1'b1, MOV_POP1, 32'h30, 1'b0);
    e = st(32'h30, 18, 16, 18, 1, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL ovf_pop1: got %h required %h", snap(), e); end
    drive(1'b1, MOV_POP2, 32'h31, 1'b0);
    e = st(32'h31, 15, 14, 16, 1, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL ovf_pop2: got %h required %h", snap(), e); end
  endtask

  task automatic test_underflow_clear();
    drive(1'b0, MOV_KEEP, 32'h0, 1'b1);
    drive(1'b1, MOV_KEEP, 32'h44, 1'b0);
    e = st(32'h44, 0, 0, 1, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL keep_empty: got %h required %h", snap(), e); end
    drive(1'b1, MOV_POP2, 32'h55, 1'b0);
    e = st(32'h55, 0, 0, 1, 0, 1);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL unf_pop2: got %h required %h", snap(), e); end
    drive(1'b0, MOV_PUSH, 32'h0, 1'b1);
    e = st(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL unf_clear: got %h required %h", snap(), e); end
    drive(1'b1, MOV_PUSH, 32'h66, 1'b0);
    drive(1'b1, MOV_POP1, 32'h67, 1'b0);
    e = st(32'h67, 0, 0, 1, 0, 1);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL unf_pop1: got %h required %h", snap(), e); end
    // pop2 at depth 3 is legal: no fault, zero fill, depth 1
    drive(1'b0, MOV_KEEP, 32'h0, 1'b1);
    for (int i = 1; i <= 3; i++) drive(1'b1, MOV_PUSH, word_t'(i), 1'b0);
    drive(1'b1, MOV_POP2, 32'h70, 1'b0);
    e = st(32'h70, 0, 0, 1, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL pop2_d3: got %h required %h", snap(), e); end
  endtask

  task automatic test_advance_hold();
    drive(1'b1, MOV_PUSH, 32'h21, 1'b0);
    drive(1'b1, MOV_PUSH, 32'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, MOV_PUSH, 32'hDEAD, 1'b0);
      e = st(32'h22, 32'h21, 32'h70, 3, 0, 0);
      n_tests++;
      if (snap() !== e) begin n_fail++; $display("FAIL hold%0d: got %h required %h", i, snap(), e); end
    end
    drive(1'b1, MOV_KEEP, 32'h12, 1'b0);
    e = st(32'h12, 32'h21, 32'h70, 3, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL keep: got %h required %h", snap(), e); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, MOV_PUSH, 32'h81, 1'b0);
    drive(1'b1, MOV_PUSH, 32'h82, 1'b0);
    sif.next_top = 32'h83;
    #3;
    reset_n = 1'b0;
    #1;
    e = st(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL async_rst: got %h required %h", snap(), e); end
    @(posedge clk);
    #1;
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL rst_hold: got %h required %h", snap(), e); end
    reset_n = 1'b1;
    drive(1'b1, MOV_PUSH, 32'h99, 1'b0);
    e = st(32'h99, 0, 0, 1, 0, 0);
    n_tests++;
    if (snap() !== e) begin n_fail++; $display("FAIL post_rst: got %h required %h", snap(), e); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_push_burst();
    test_pops();
    test_overflow();
    test_underflow_clear();
    test_advance_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_dstack_regs
`default_nettype wire
